// File: rtl/acc_processor_core.sv
// Accumulator processor core: FETCH/DECODE/EXECUTE/HALT sequencing with
// Z/C flags, jumps, shifts and an output port strobed for one cycle per OUT.
// The program ROM answers combinationally on instr_in for program_counter.
module acc_processor_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned OPC_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OPC_W+DATA_W-1:0] instr_in,
  output logic [ADDR_W-1:0]       program_counter,
  output logic [DATA_W-1:0]       accumulator,
  output logic                    zero_flag,
  output logic                    carry_flag,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    data_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOT  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_JMP  = 4'hA,
    OP_JZ   = 4'hB,
    OP_JC   = 4'hC,
    OP_JNZ  = 4'hD,
    OP_OUT  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  state_t                    state_q;
  logic [OPC_W+DATA_W-1:0]   ir_q;
  opcode_t                   opc_q;
  logic [DATA_W-1:0]         opr_q;
  logic [DATA_W-1:0]         acc_q;
  logic [ADDR_W-1:0]         pc_q;
  logic                      z_q;
  logic                      c_q;
  logic [DATA_W-1:0]         out_data_q;
  logic                      out_valid_q;
  logic                      busy_q;
  logic                      ready_q;

  logic [DATA_W-1:0]         acc_d;
  logic                      z_d;
  logic                      c_d;
  logic                      jump_d;
  logic [DATA_W:0]           sum;
  opcode_t                   ir_op;
  logic [ADDR_W-1:0]         tgt;

  assign ir_op = opcode_t'(ir_q[OPC_W+DATA_W-1:DATA_W]);
  assign tgt   = opr_q[ADDR_W-1:0];

  // ALU and branch decision for the instruction held in the opcode/operand registers
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, opr_q};
    acc_d  = acc_q;
    z_d    = z_q;
    c_d    = c_q;
    jump_d = 1'b0;
    case (opc_q)
      OP_LDI: acc_d = opr_q;
      OP_ADD: {c_d, acc_d} = sum;
      OP_SUB: begin
        acc_d = acc_q - opr_q;
        c_d   = (acc_q < opr_q);
      end
      OP_AND: begin
        acc_d = acc_q & opr_q;
        c_d   = 1'b0;
      end
      OP_OR: begin
        acc_d = acc_q | opr_q;
        c_d   = 1'b0;
      end
      OP_XOR: begin
        acc_d = acc_q ^ opr_q;
        c_d   = 1'b0;
      end
      OP_NOT: begin
        acc_d = ~acc_q;
        c_d   = 1'b0;
      end
      OP_SHL: begin
        c_d   = acc_q[DATA_W-1];
        acc_d = {acc_q[DATA_W-2:0], 1'b0};
      end
      OP_SHR: begin
        c_d   = acc_q[0];
        acc_d = {1'b0, acc_q[DATA_W-1:1]};
      end
      OP_JMP: jump_d = 1'b1;
      OP_JZ:  jump_d = z_q;
      OP_JC:  jump_d = c_q;
      OP_JNZ: jump_d = ~z_q;
      default: ;
    endcase
    // Z tracks the result of data-processing ops only (LDI..SHR)
    if (opc_q >= OP_LDI && opc_q <= OP_SHR) begin
      z_d = (acc_d == '0);
    end
  end

  // Sequencer with all architectural state and registered status outputs.
  // busy/data_ready/out_valid are loaded from the state being entered so they
  // line up with that state's cycle; out_data is captured on entry to the
  // EXECUTE of an OUT so data and strobe appear together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      opc_q       <= OP_NOP;
      opr_q       <= '0;
      acc_q       <= '0;
      pc_q        <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            acc_q   <= '0;
            pc_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir_q    <= instr_in;
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          opc_q <= ir_op;
          opr_q <= ir_q[DATA_W-1:0];
          if (ir_op == OP_HALT) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            if (ir_op == OP_OUT) begin
              out_valid_q <= 1'b1;
              out_data_q  <= acc_q;
            end
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc_q <= acc_d;
          z_q   <= z_d;
          c_q   <= c_d;
          if (jump_d) begin
            pc_q <= tgt;
          end
          state_q <= S_FETCH;
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign program_counter = pc_q;
  assign accumulator     = acc_q;
  assign zero_flag       = z_q;
  assign carry_flag      = c_q;
  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign busy            = busy_q;
  assign data_ready      = ready_q;

endmodule

// File: tb/tb_acc_processor_core.sv
// Bench for acc_processor_core: instruction-level reference model compared
// every cycle against the 8-bit core, directed programs with literal
// expectations, async reset abort, and a 4-bit-address instance for pc wrap.
module tb_acc_processor_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] rom [256];
  logic [11:0] instr_in;
  logic [7:0]  program_counter;
  logic [7:0]  accumulator;
  logic        zero_flag, carry_flag;
  logic [7:0]  out_data;
  logic        out_valid, busy, data_ready;

  logic        start4;
  logic [11:0] rom4 [16];
  logic [11:0] instr4;
  logic [3:0]  pc4;
  logic [7:0]  acc4, out4;
  logic        z4, c4, ov4, busy4, dr4;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  assign instr_in = rom[program_counter];
  assign instr4   = rom4[pc4];

  acc_processor_core u_dut (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
    .program_counter(program_counter), .accumulator(accumulator),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .data_ready(data_ready)
  );

  acc_processor_core #(.DATA_W(8), .ADDR_W(4), .OPC_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .instr_in(instr4),
    .program_counter(pc4), .accumulator(acc4),
    .zero_flag(z4), .carry_flag(c4), .out_data(out4),
    .out_valid(ov4), .busy(busy4), .data_ready(dr4)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

  // ---------------- reference model (instruction level) ----------------
  typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
  mode_t m_mode = M_IDLE;
  int m_acc = 0, m_pc = 0, m_z = 0, m_c = 0, m_out = 0, m_slot = 0;
  int m_op = 0, m_imm = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_acc = 0; m_pc = 0; m_z = 0; m_c = 0; m_out = 0;
      m_slot = 0; m_op = 0; m_imm = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_HALT: begin
          if (start) begin
            m_acc = 0; m_pc = 0; m_z = 0; m_c = 0;
            m_mode = M_RUN; m_slot = 0;
          end
        end
        default: begin
          if (m_slot == 0) begin
            m_op   = int'(rom[m_pc][11:8]);
            m_imm  = int'(rom[m_pc][7:0]);
            m_pc   = (m_pc + 1) % 256;
            m_slot = 1;
          end else if (m_slot == 1) begin
            if (m_op == 15) m_mode = M_HALT;
            else begin
              if (m_op == 14) m_out = m_acc;
              m_slot = 2;
            end
          end else begin
            case (m_op)
              1:  m_acc = m_imm;
              2:  begin m_acc = m_acc + m_imm; m_c = (m_acc > 255) ? 1 : 0; m_acc = m_acc % 256; end
              3:  begin m_c = (m_acc < m_imm) ? 1 : 0; m_acc = (m_acc - m_imm + 256) % 256; end
              4:  begin m_acc = m_acc & m_imm; m_c = 0; end
              5:  begin m_acc = m_acc | m_imm; m_c = 0; end
              6:  begin m_acc = m_acc ^ m_imm; m_c = 0; end
              7:  begin m_acc = 255 - m_acc; m_c = 0; end
              8:  begin m_c = (m_acc >= 128) ? 1 : 0; m_acc = (m_acc * 2) % 256; end
              9:  begin m_c = m_acc % 2; m_acc = m_acc / 2; end
              10: m_pc = m_imm;
              11: if (m_z == 1) m_pc = m_imm;
              12: if (m_c == 1) m_pc = m_imm;
              13: if (m_z == 0) m_pc = m_imm;
              default: ;
            endcase
            if (m_op >= 1 && m_op <= 9) m_z = (m_acc == 0) ? 1 : 0;
            m_slot = 0;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", int'(program_counter), m_pc);
      check("acc", int'(accumulator), m_acc);
      check("zero", int'(zero_flag), m_z);
      check("carry", int'(carry_flag), m_c);
      check("out_data", int'(out_data), m_out);
      check("out_valid", int'(out_valid),
            (m_mode == M_RUN && m_slot == 2 && m_op == 14) ? 1 : 0);
      check("busy", int'(busy), (m_mode == M_RUN) ? 1 : 0);
      check("data_ready", int'(data_ready), (m_mode == M_HALT) ? 1 : 0);
    end
  end

  // Record every OUT strobe for literal checks
  int pulse_data[$];
  int pulse_carry[$];
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      pulse_data.push_back(int'(out_data));
      pulse_carry.push_back(int'(carry_flag));
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  // Called at a negedge with the core idle or halted; returns the cycle
  // number (FETCH entry cycle = 1) at which data_ready is first seen.
  task automatic run_prog(input int hold, output int n);
    start = 1'b1;
    n = 0;
    repeat (hold) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    while (data_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (data_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got data_ready=%0b expected 1 within 300 cycles", data_ready);
    end
  endtask

  int n;

  initial begin
    reset = 1'b0; start = 1'b0; start4 = 1'b0;
    clear_rom();
    for (int i = 0; i < 16; i++) rom4[i] = 12'h000;

    #12;
    check("rst_acc", int'(accumulator), 0);
    check("rst_pc", int'(program_counter), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(data_ready), 0);
    check("rst_outv", int'(out_valid), 0);
    check("rst_outd", int'(out_data), 0);
    check("rst_flags", int'({zero_flag, carry_flag}), 0);

    @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start", int'(busy), 0);

    // Basic add
    rom[0] = ins(4'h1, 8'h05); rom[1] = ins(4'h2, 8'h03); rom[2] = ins(4'hF, 8'h00);
    run_prog(1, n);
    check("add_cycles", n, 9);
    check("add_acc", int'(accumulator), 8'h08);
    check("add_pc", int'(program_counter), 3);
    check("add_zc", int'({zero_flag, carry_flag}), 0);
    check("add_busy", int'(busy), 0);

    // Carry and borrow
    clear_rom();
    rom[0] = ins(4'h1, 8'hF0); rom[1] = ins(4'h2, 8'h20); rom[2] = ins(4'hE, 8'h00);
    rom[3] = ins(4'h3, 8'h11); rom[4] = ins(4'hE, 8'h00); rom[5] = ins(4'h4, 8'h00);
    rom[6] = ins(4'hF, 8'h00);
    pulse_data.delete(); pulse_carry.delete();
    run_prog(1, n);
    check("cb_pulses", pulse_data.size(), 2);
    if (pulse_data.size() == 2) begin
      check("cb_add_acc", pulse_data[0], 8'h10);
      check("cb_add_c", pulse_carry[0], 1);
      check("cb_sub_acc", pulse_data[1], 8'hFF);
      check("cb_sub_c", pulse_carry[1], 1);
    end
    check("cb_and_acc", int'(accumulator), 0);
    check("cb_and_z", int'(zero_flag), 1);
    check("cb_and_c", int'(carry_flag), 0);

    // Countdown loop, start held two cycles (second cycle ignored while busy)
    clear_rom();
    rom[0] = ins(4'h1, 8'h03); rom[1] = ins(4'h3, 8'h01);
    rom[2] = ins(4'hD, 8'h01); rom[3] = ins(4'hF, 8'h00);
    run_prog(2, n);
    check("loop_cycles", n, 24);
    check("loop_acc", int'(accumulator), 0);
    check("loop_zc", int'({zero_flag, carry_flag}), 2);
    check("loop_pc", int'(program_counter), 4);

    // Output port
    clear_rom();
    rom[0] = ins(4'h1, 8'hA5); rom[1] = ins(4'hE, 8'h00); rom[2] = ins(4'h8, 8'h00);
    rom[3] = ins(4'hE, 8'h00); rom[4] = ins(4'hF, 8'h00);
    pulse_data.delete(); pulse_carry.delete();
    run_prog(1, n);
    check("out_pulses", pulse_data.size(), 2);
    if (pulse_data.size() == 2) begin
      check("out_first", pulse_data[0], 8'hA5);
      check("out_second", pulse_data[1], 8'h4A);
      check("out_shl_c", pulse_carry[1], 1);
    end
    check("out_hold", int'(out_data), 8'h4A);

    // Async reset during EXECUTE of ADD
    clear_rom();
    rom[0] = ins(4'h1, 8'h01); rom[1] = ins(4'h2, 8'h02); rom[2] = ins(4'hF, 8'h00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_acc", int'(accumulator), 1);
    check("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_acc", int'(accumulator), 0);
    check("arst_pc", int'(program_counter), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_outd", int'(out_data), 0);
    check("arst_flags", int'({zero_flag, carry_flag}), 0);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle_busy", int'(busy), 0);
    check("post_rst_idle_pc", int'(program_counter), 0);
    check("post_rst_idle_acc", int'(accumulator), 0);

    // ADDR_W=4: halt at 5, restart, then free-run wrap
    rom4[5] = ins(4'hF, 8'h00);
    start4 = 1'b1;
    n = 0;
    @(negedge clk); n++;
    start4 = 1'b0;
    while (dr4 !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    check("w4_halt_cycles", n, 18);
    check("w4_halt_pc", int'(pc4), 6);
    check("w4_halt_busy", int'(busy4), 0);
    rom4[5] = 12'h000;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("w4_restart_pc", int'(pc4), 0);
    check("w4_restart_busy", int'(busy4), 1);
    check("w4_restart_ready", int'(dr4), 0);
    check("w4_restart_acc", int'(acc4), 0);
    for (int k = 1; k <= 18; k++) begin
      repeat (3) @(negedge clk);
      check("w4_wrap_pc", int'(pc4), k % 16);
    end
    check("w4_still_busy", int'(busy4), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_processor_core.md
Name: acc_processor_core

Overview:
- Parametrised successor to the 8-bit accumulator processor: same fetch/decode/execute/halt sequencing, generalised data and address widths.
- Adds zero/carry flags, conditional and unconditional jumps, shifts, an output port with a valid strobe, and restart from HALT.
- Sits between the external program ROM, which supplies `instr_in` combinationally from `program_counter`, and the display/output logic fed by `accumulator`, `out_data` and `data_ready`.

Parameters:
- DATA_W, 8, accumulator/operand width.
- ADDR_W, 8, program-counter width; must be <= DATA_W.
- OPC_W, 4, opcode width (fixed 4; opcode decode assumes 16 codes).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled in IDLE and HALT.
- instr_in  input  OPC_W+DATA_W  instruction at program_counter; [top 4] opcode, [DATA_W-1:0] operand.
- program_counter  output  ADDR_W  program ROM address.
- accumulator  output  DATA_W  accumulator register.
- zero_flag  output  1  Z flag.
- carry_flag  output  1  C flag.
- out_data  output  DATA_W  value of the last OUT instruction.
- out_valid  output  1  one-cycle pulse on OUT.
- busy  output  1  high in FETCH/DECODE/EXECUTE.
- data_ready  output  1  high while in HALT.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed): state=IDLE; all outputs and internal registers (instruction reg, operand reg, opcode reg) = 0.
- States:
  - IDLE: start=1 -> clear acc, pc, Z, C; go to FETCH.
  - FETCH: latch instr_in; pc <= pc+1 (mod 2^ADDR_W, wraps silently); go to DECODE.
  - DECODE: split opcode/operand; opcode 0xF -> HALT, else -> EXECUTE.
  - EXECUTE: perform op; go to FETCH.
  - HALT: data_ready=1; start=1 -> clear acc, pc, Z, C and go to FETCH.
- Every non-halt instruction takes exactly 3 cycles (FETCH, DECODE, EXECUTE).
- Opcodes (imm = operand; tgt = operand[ADDR_W-1:0]):
  - 0 NOP.
  - 1 LDI: acc=imm; Z updated; C unchanged.
  - 2 ADD: {C,acc}=acc+imm.
  - 3 SUB: acc=acc-imm; C=1 if borrow (acc<imm unsigned).
  - 4 AND, 5 OR, 6 XOR: with imm; C=0.
  - 7 NOT: acc=~acc; C=0.
  - 8 SHL: C=acc[MSB]; acc<<1, LSB filled with 0.
  - 9 SHR: C=acc[0]; acc>>1, MSB filled with 0.
  - A JMP: pc=tgt.
  - B JZ: if Z, pc=tgt.
  - C JC: if C, pc=tgt.
  - D JNZ: if !Z, pc=tgt.
  - E OUT: out_data=acc; out_valid=1 for that single cycle.
  - F HALT.
- Flags:
  - Z = (new acc == 0) for opcodes 1-9 only.
  - Jumps, NOP and OUT leave Z and C unchanged.
  - Flags are evaluated on the pre-jump values.
- Jump write in EXECUTE overrides the FETCH increment; jump taken → next FETCH reads tgt.
- Arithmetic is modulo 2^DATA_W; the carry is the only overflow indication.
- out_valid = 0 in every cycle except the EXECUTE of an OUT.
- out_data holds its value until the next OUT or a reset.
- data_ready = 0 in all states except HALT.
- busy = 0 in IDLE and HALT.
- start is ignored while busy.
- start held high in HALT restarts once per HALT entry, i.e. after the HALT instruction is re-fetched.
- Reset asserted mid-instruction aborts it; no partial accumulator, pc or flag update survives.

Test Plan:
- Basic add (DATA_W=8): ROM {0:LDI 05, 1:ADD 03, 2:HALT}, pulse start → acc=0x08, Z=0, C=0, pc=3, data_ready=1 exactly 9 cycles after FETCH entry; busy low in HALT.
- Carry and borrow:
  - LDI F0, ADD 20 → acc=0x10, C=1, Z=0.
  - then SUB 11 → acc=0xFF, C=1.
  - then AND 00 → acc=0x00, Z=1, C=0.
- Countdown loop: ROM {0:LDI 03, 1:SUB 01, 2:JNZ 01, 3:HALT} → SUB executes 3 times; halts with acc=0, Z=1, C=0, pc=4.
- Output port: LDI A5, OUT, SHL, OUT, HALT →
  - out_valid pulses exactly twice, each 1 cycle wide.
  - out_data = 0xA5 then 0x4A.
  - C=1 after the SHL.
- Async reset: drop reset between clock edges during EXECUTE of ADD → all outputs 0 and state IDLE immediately; after release, no activity until start.
- Wrap and restart (ADDR_W=4): ROM of 16 NOPs except addr 5 = HALT, with a JMP 0 at addr 15 removed → pc runs 0..5; assert start in HALT → acc/pc cleared, execution resumes from addr 0. Separate run with all NOPs → pc wraps 15→0 with no error.
